// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/status bundle between the control unit and pc_unit
//
// Purpose: groups the next-address controls and PC/RAS status of pc_unit.
//   master : control side (drives PCWre, PCSrc, offset, target, trap_req)
//   slave  : pc_unit side (drives currentAddress, epc, ras_* flags)
// Signals:
//   PCWre          PC write enable (0 = stall)
//   PCSrc[2:0]     next-address select
//   offset         signed branch offset, OFF_W bits
//   target         absolute jump/call target, ADDR_W bits
//   trap_req       trap request
//   currentAddress registered PC
//   epc            registered exception PC
//   ras_empty/full RAS occupancy decoded from the registered count
//   ras_ovf/unf    sticky overflow / underflow flags
interface pc_unit_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 12
);
  logic              PCWre;
  logic [2:0]        PCSrc;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] target;
  logic              trap_req;
  logic [ADDR_W-1:0] currentAddress;
  logic [ADDR_W-1:0] epc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output PCWre, PCSrc, offset, target, trap_req,
    input  currentAddress, epc, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  PCWre, PCSrc, offset, target, trap_req,
    output currentAddress, epc, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with return-address stack and EPC
//
// Purpose: registered PC with sequential, branch, jump, call, return,
//   exception-return and trap-entry next-address selection.
// Ports:
//   CLK    clock, all state changes on the rising edge
//   RESET  synchronous reset, active-high, overrides everything
//   bus    pc_unit_if.slave (controls in, PC/EPC/RAS status out)
// Priority per edge: RESET > trap_req > PCWre=0 hold > PCSrc.
module pc_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                OFF_W     = 12,
  parameter int                PC_STEP   = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = 16'h0004,
  parameter int                RAS_DEPTH = 4
) (
  input logic       CLK,
  input logic       RESET,
  pc_unit_if.slave  bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] SRC_SEQ  = 3'd0;
  localparam logic [2:0] SRC_BR   = 3'd1;
  localparam logic [2:0] SRC_JMP  = 3'd2;
  localparam logic [2:0] SRC_CALL = 3'd3;
  localparam logic [2:0] SRC_RET  = 3'd4;
  localparam logic [2:0] SRC_ERET = 3'd5;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q, unf_q;

  logic              push, pop, unf_set;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] off_ext;
  logic [PTR_W-1:0]  push_ptr;
  logic              ras_is_empty, ras_is_full;

  assign ras_is_empty = (cnt_q == '0);
  assign ras_is_full  = (cnt_q == CNT_FULL);
  assign pc_seq       = pc_q + ADDR_W'(PC_STEP);
  assign off_ext      = {{(ADDR_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
  // top_q points at the newest entry; when full, top+1 is the oldest slot,
  // so a push there overwrites the oldest return address.
  assign push_ptr     = top_q + PTR_W'(1);

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    push    = 1'b0;
    pop     = 1'b0;
    unf_set = 1'b0;
    if (bus.trap_req) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
    end else if (bus.PCWre) begin
      case (bus.PCSrc)
        SRC_BR:   pc_d = pc_q + off_ext;
        SRC_JMP:  pc_d = bus.target;
        SRC_CALL: begin
          pc_d = bus.target;
          push = 1'b1;
        end
        SRC_RET: begin
          if (ras_is_empty) begin
            // Return with nothing to return to is handled as a trap.
            pc_d    = TRAP_VEC;
            epc_d   = pc_q;
            unf_set = 1'b1;
          end else begin
            pc_d = ras_mem[top_q];
            pop  = 1'b1;
          end
        end
        SRC_ERET: pc_d = epc_q;
        default:  pc_d = pc_seq;  // SEQ and reserved encodings
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      if (unf_set) unf_q <= 1'b1;
      if (push) begin
        ras_mem[push_ptr] <= pc_seq;
        top_q             <= push_ptr;
        if (ras_is_full) ovf_q <= 1'b1;
        else             cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        top_q <= top_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bus.currentAddress = pc_q;
  assign bus.epc            = epc_q;
  assign bus.ras_empty      = ras_is_empty;
  assign bus.ras_full       = ras_is_full;
  assign bus.ras_ovf        = ovf_q;
  assign bus.ras_unf        = unf_q;

endmodule
